// File: rtl/weight_assembler.sv
// Rebuilds an N-bit word from a set-bit count and an ascending stream of
// set-bit locations, presenting the result on a held valid/ready output.
module weight_assembler #(
    parameter int unsigned N  = 8,
    parameter int unsigned LW = $clog2(N),
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] pc,
    output logic          busy,
    input  logic          loc_valid,
    input  logic [LW-1:0] loc,
    output logic          loc_ready,
    output logic [N-1:0]  r_out,
    output logic          err,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] rem;
    logic [LW-1:0] last_loc;
    logic          have_prev;
    logic          beat;
    logic          pc_over;
    logic          pc_zero;

    assign beat    = loc_valid && loc_ready;
    assign pc_over = (pc > CW'(N));
    assign pc_zero = (pc == '0);

    // r_out doubles as the accumulator, so it shows the partial word during COLLECT
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r_out     <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            loc_ready <= 1'b0;
            busy      <= 1'b0;
            rem       <= '0;
            last_loc  <= '0;
            have_prev <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r_out     <= '0;
                        rem       <= pc;
                        err       <= pc_over;
                        last_loc  <= '0;
                        have_prev <= 1'b0;
                        busy      <= 1'b1;
                        if (pc_zero || pc_over) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state     <= COLLECT;
                            loc_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (beat) begin
                        r_out <= r_out | (N'(1) << loc);
                        // Non-ascending location (including duplicates) flags the frame
                        if (have_prev && (loc <= last_loc)) begin
                            err <= 1'b1;
                        end
                        last_loc  <= loc;
                        have_prev <= 1'b1;
                        if (rem != '0) begin
                            rem <= rem - CW'(1);
                        end
                        if (rem <= CW'(1)) begin
                            state     <= DONE;
                            loc_ready <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    loc_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_assembler.sv
// Scoreboard bench for weight_assembler: expected words are queued when a
// frame is driven and compared when the block presents its result.
module tb_weight_assembler;

    localparam int unsigned N  = 8;
    localparam int unsigned LW = 3;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [N-1:0] r;
        logic         e;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] pc;
    logic          busy;
    logic          loc_valid;
    logic [LW-1:0] loc;
    logic          loc_ready;
    logic [N-1:0]  r_out;
    logic          err;
    logic          out_valid;
    logic          out_ready;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   beats[$];

    weight_assembler #(.N(N), .LW(LW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pc        (pc),
        .busy      (busy),
        .loc_valid (loc_valid),
        .loc       (loc),
        .loc_ready (loc_ready),
        .r_out     (r_out),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a result, compare it against the scoreboard, then accept it
    task automatic collect();
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        if (!out_valid) begin
            check("out_timeout", 32'(out_valid), 32'd1);
        end else if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("r_out", 32'(r_out), 32'(e.r));
            check("err", 32'(err), 32'(e.e));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("busy_drop", 32'(busy), 32'd0);
    endtask

    // Drive one frame using the beats queue; optionally leave the result unaccepted
    task automatic run_frame(input int npc, input bit bubbles, input bit release_now);
        exp_t         e;
        logic [N-1:0] acc;
        bit           bad;
        acc = '0;
        bad = 1'b0;
        if (npc == 0 || npc > int'(N)) begin
            e.r = '0;
            e.e = (npc > int'(N));
        end else begin
            foreach (beats[i]) begin
                acc[beats[i]] = 1'b1;
                if (i > 0 && beats[i] <= beats[i-1]) bad = 1'b1;
            end
            e.r = acc;
            e.e = bad;
        end
        exp_q.push_back(e);
        start = 1'b1;
        pc    = CW'(npc);
        step();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        if (npc >= 1 && npc <= int'(N)) begin
            foreach (beats[i]) begin
                if (bubbles) begin
                    repeat ($urandom_range(0, 2)) begin
                        check("stall_no_out", 32'(out_valid), 32'd0);
                        step();
                    end
                end
                loc_valid = 1'b1;
                loc       = LW'(beats[i]);
                check("loc_ready", 32'(loc_ready), 32'd1);
                step();
                loc_valid = 1'b0;
            end
        end else begin
            check("no_loc_ready", 32'(loc_ready), 32'd0);
        end
        check("out_latency", 32'(out_valid), 32'd1);
        if (release_now) collect();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pc        = '0;
        loc_valid = 1'b0;
        loc       = '0;
        out_ready = 1'b0;

        // Reset with random inputs
        repeat (2) begin
            start     = 1'($urandom);
            pc        = CW'($urandom);
            loc_valid = 1'($urandom);
            loc       = LW'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        check("rst_r_out", 32'(r_out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_loc_ready", 32'(loc_ready), 32'd0);
        rst       = 1'b0;
        start     = 1'b0;
        loc_valid = 1'b0;
        out_ready = 1'b0;
        step();

        // Normal frame: 0,2,4 -> 8'h15
        beats = '{0, 2, 4};
        run_frame(3, 1'b0, 1'b1);

        // Zero and overflow counts
        beats = {};
        run_frame(0, 1'b0, 1'b1);
        run_frame(9, 1'b0, 1'b1);

        // Full frame under backpressure with ignored start/loc pulses
        beats = '{0, 1, 2, 3, 4, 5, 6, 7};
        run_frame(8, 1'b0, 1'b0);
        repeat (5) begin
            start     = 1'b1;
            pc        = CW'(2);
            loc_valid = 1'b1;
            loc       = LW'(3);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_r_out", 32'(r_out), 32'hFF);
            check("hold_loc_ready", 32'(loc_ready), 32'd0);
            step();
        end
        start     = 1'b0;
        loc_valid = 1'b0;
        collect();
        step();
        check("ignored_start", 32'(busy), 32'd0);

        // Ordering error: 5,5,1 -> 8'h22 with err
        beats = '{5, 5, 1};
        run_frame(3, 1'b0, 1'b1);

        // Round trip against a locator model
        for (int r = 0; r < 32; r++) begin
            logic [N-1:0] rv;
            rv    = N'(r);
            beats = {};
            for (int b = 0; b < int'(N); b++) begin
                if (rv[b]) beats.push_back(b);
            end
            run_frame(beats.size(), 1'b1, 1'b1);
        end

        // Mid-frame reset after 2 of 4 beats
        start = 1'b1;
        pc    = CW'(4);
        step();
        start = 1'b0;
        loc_valid = 1'b1;
        loc       = LW'(1);
        step();
        loc       = LW'(3);
        step();
        loc_valid = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_loc_ready", 32'(loc_ready), 32'd0);
        step();
        check("midrst_no_output", 32'(out_valid), 32'd0);
        beats = '{6, 7};
        run_frame(2, 1'b0, 1'b1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_assembler.md
# weight_assembler

Sequential inverse of the weight locator: rebuilds an N-bit word from its population count and a stream of set-bit locations. A frame starts with a count command, then accepts one location index per cycle over a valid/ready handshake, and finally presents the rebuilt word on a held output handshake. It sits on the receive side of the weight-location path. Its output must match the weight locator's input whenever the locator's PC and L0..L(PC-1) are streamed in.

## Interface

Parameters:

- N, 8, word width; power of two, at least 2.
- LW, $clog2(N), location index width (3 when N=8).
- CW, $clog2(N+1), count width (4 when N=8).

Ports:

- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  frame start, qualified with pc.
- pc  in  CW  number of set bits in the frame.
- busy  out  1  high whenever the block is not IDLE.
- loc_valid  in  1  location beat valid.
- loc  in  LW  bit index to set.
- loc_ready  out  1  location beat accepted when loc_valid is also high.
- r_out  out  N  rebuilt word.
- err  out  1  frame error flag; valid only while out_valid is high.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.

## Operation

- States: IDLE, COLLECT, DONE.
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - r_out=0, err=0, out_valid=0, loc_ready=0, busy=0.
  - The remaining-count register and the last-index register are cleared.
  - Reset overrides any in-flight frame with no output produced; it also overrides every other input that cycle.
- IDLE:
  - start is sampled only in this state.
  - On start, the accumulator is cleared and rem is set to pc.
  - pc=0: go to DONE with r_out=0, err=0.
  - pc>N: go to DONE with r_out=0, err=1; no location beats are consumed.
  - 1≤pc≤N: go to COLLECT.
- COLLECT:
  - loc_ready=1.
  - On each loc_valid&loc_ready beat: set bit loc of the accumulator and decrement rem.
  - Locations must be strictly ascending, matching the locator's L0, L1, ... order.
  - A beat with loc ≤ the previous loc in the same frame sets the sticky err. This covers duplicates. The bit is still ORed in.
  - The first beat of a frame has no ordering check.
  - When the beat that takes rem to 0 is accepted, go to DONE.
- DONE:
  - out_valid=1.
  - r_out and err are held stable until out_valid&out_ready.
  - On that handshake, go to IDLE; out_valid drops the next cycle.
  - start is ignored while in this state.
- In any state other than IDLE, start is ignored and does not queue.
- In any state other than COLLECT, loc_valid is ignored and loc_ready=0.
- Arithmetic:
  - rem is CW bits, unsigned, and never decrements below 0.
  - The accumulator is N bits and built only by OR.

## Timing

- start accepted at edge t: busy=1 from t+1.
- pc=0 or pc>N: out_valid=1 from t+1 (one-cycle latency).
- Collecting frames: loc_ready=1 from t+1, and one beat is accepted per cycle at full throughput. If the last beat is accepted at edge u, out_valid=1 from u+1.
- Minimum frame length with continuous beats is pc+1 cycles from start to out_valid.
- Output acceptance at edge v: state is IDLE at v+1. The earliest new start is sampled at edge v+1, so there is one bubble between frames.
- r_out during COLLECT shows the partial accumulator; it is not qualified.
- Bubbles on loc_valid stall COLLECT indefinitely; there is no timeout.

## Test plan

- Reset: hold rst for 2 cycles with random inputs -> r_out=0, out_valid=0, busy=0, loc_ready=0.
- Normal frame: start with pc=3, then stream loc 0, 2, 4 on consecutive cycles with out_ready=1.
  - out_valid rises 1 cycle after the third beat, with r_out=8'h15, err=0.
  - busy drops the cycle after acceptance.
- Zero and overflow counts:
  - start with pc=0 -> next cycle out_valid=1, r_out=0, err=0.
  - start with pc=9 -> out_valid=1, r_out=0, err=1, and loc_ready never rises.
- Backpressure and ignored inputs:
  - Run a pc=8 frame with loc 0..7, then hold out_ready=0 for 5 cycles.
  - r_out=8'hFF and out_valid are held throughout.
  - start and loc_valid pulses during the hold have no effect.
  - Raise out_ready -> IDLE next cycle.
- Ordering error: start with pc=3 and loc 5, 5, 1 -> r_out=8'h22, err=1.
- Round trip and mid-frame reset:
  - For R=0..31, drive the locator with R and stream its PC/L outputs in, with random loc_valid bubbles -> r_out==R and err=0 for every value.
  - Assert rst after 2 of 4 beats -> IDLE next cycle with no out_valid, and the following frame completes correctly.
